shift_reg_feeder: RTL

//   Buffers bytes from a producer (valid/ready handshake) and issues them one
//   at a time to the 74HC595 serial output driver.
//   - Interface to the driver: a byte value plus a toggle strobe.
//   - Guarantees each byte is stable before its toggle edge.
//   - Guarantees toggle edges are spaced far enough apart that the driver

---
 rtl/shift_reg_feeder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/shift_reg_feeder.sv
// Byte FIFO feeding the 74HC595 serial driver: presents one byte at a time
// and flips a toggle strobe per byte, spacing strobes so each frame completes.
`timescale 1ns/1ps
module shift_reg_feeder #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned GAP_CYCLES  = 24,
    parameter int unsigned SKIP_REPEAT = 0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [7:0]               i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [7:0]               o_value,
    output logic                     o_enable_toggle,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned CW = $clog2(GAP_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [7:0]      value_next;
    logic            toggle_next;
    logic            have_issued, issued_next;

    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [LW-1:0]   level;
    logic            push, pop;
    logic [7:0]      head;

    assign o_ready = (level < LW'(DEPTH));
    assign push    = i_valid && o_ready;
    assign head    = mem[rd_ptr];
    assign o_level = level;
    assign o_busy  = (state != IDLE) || (level != '0);

    // Storage array carries no reset; validity is tracked by level.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= IDLE;
            cnt             <= '0;
            o_value         <= 8'h00;
            o_enable_toggle <= 1'b0;
            have_issued     <= 1'b0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            o_value         <= value_next;
            o_enable_toggle <= toggle_next;
            have_issued     <= issued_next;
        end
    end

    // Value is loaded one cycle ahead of the strobe so it is stable at the edge.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        value_next  = o_value;
        toggle_next = o_enable_toggle;
        issued_next = have_issued;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop = 1'b1;
                    if (!((SKIP_REPEAT != 32'd0) && have_issued && (head == o_value))) begin
                        value_next = head;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                toggle_next = ~o_enable_toggle;
                issued_next = 1'b1;
                cnt_next    = CW'(GAP_CYCLES - 1);
                state_next  = HOLD;
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
